// File: rtl/rect_drawer.sv
// rect_drawer
// Rectangle rasteriser for the VGA adapter path. It takes an origin, a size and
// a colour, then writes the rectangle one pixel per clock in row-major order.
// Pixels outside the screen are clipped: they use a raster cycle but do not plot.
//
// Ports
//   clock      : system clock; all logic runs on the rising edge
//   reset      : synchronous reset, active low
//   start      : draw request; only sampled while idle
//   erase      : paint bg_colour instead of colour_in (captured with start)
//   hold       : stall the raster; counters freeze and nothing is plotted
//   x_in, y_in : top-left origin of the rectangle
//   w_in, h_in : rectangle size in pixels (0 means nothing is drawn)
//   colour_in  : draw colour
//   bg_colour  : erase colour
//   busy       : a draw is in progress, including the done cycle
//   done       : one-cycle pulse that follows the last pixel
//   x_out, y_out, colour_out, plot_out : pixel write port to the VGA adapter
module rect_drawer #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 9,
    parameter int DIM_W    = 5,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                erase,
    input  logic                hold,
    input  logic [X_W-1:0]      x_in,
    input  logic [Y_W-1:0]      y_in,
    input  logic [DIM_W-1:0]    w_in,
    input  logic [DIM_W-1:0]    h_in,
    input  logic [COLOUR_W-1:0] colour_in,
    input  logic [COLOUR_W-1:0] bg_colour,
    output logic                busy,
    output logic                done,
    output logic [X_W-1:0]      x_out,
    output logic [Y_W-1:0]      y_out,
    output logic [COLOUR_W-1:0] colour_out,
    output logic                plot_out
);

    // FLUSH is the cycle in which the last pixel sits on the outputs, so done
    // arrives one cycle after that pixel rather than together with it.
    typedef enum logic [1:0] {IDLE, DRAW, FLUSH, FINISH} state_t;

    state_t              state_q, state_d;
    logic [X_W-1:0]      x0_q, x0_d;
    logic [Y_W-1:0]      y0_q, y0_d;
    logic [DIM_W-1:0]    w_q, w_d;
    logic [DIM_W-1:0]    h_q, h_d;
    logic [COLOUR_W-1:0] col_q, col_d;
    logic [DIM_W-1:0]    cx_q, cx_d;
    logic [DIM_W-1:0]    cy_q, cy_d;

    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [X_W-1:0]      xo_q, xo_d;
    logic [Y_W-1:0]      yo_q, yo_d;
    logic [COLOUR_W-1:0] co_q, co_d;
    logic                plot_q, plot_d;

    // Sums carry one extra bit so that wrap-around past the coordinate width
    // is seen as off-screen rather than aliasing back onto the left or top.
    logic [X_W:0] sum_x;
    logic [Y_W:0] sum_y;
    logic         clip;

    always_comb begin
        sum_x = {1'b0, x0_q} + (X_W+1)'(cx_q);
        sum_y = {1'b0, y0_q} + (Y_W+1)'(cy_q);
        clip  = (sum_x >= (X_W+1)'(SCREEN_W)) || sum_x[X_W]
             || (sum_y >= (Y_W+1)'(SCREEN_H)) || sum_y[Y_W];

        state_d = state_q;
        x0_d    = x0_q;
        y0_d    = y0_q;
        w_d     = w_q;
        h_d     = h_q;
        col_d   = col_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        xo_d    = xo_q;
        yo_d    = yo_q;
        co_d    = co_q;
        plot_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    x0_d  = x_in;
                    y0_d  = y_in;
                    w_d   = w_in;
                    h_d   = h_in;
                    col_d = erase ? bg_colour : colour_in;
                    cx_d  = '0;
                    cy_d  = '0;
                    if (w_in == '0 || h_in == '0) begin
                        state_d = FINISH;
                    end else begin
                        state_d = DRAW;
                    end
                end
            end
            DRAW: begin
                // While held, nothing changes and the pixel outputs keep
                // their last values; only plot drops.
                if (!hold) begin
                    xo_d   = sum_x[X_W-1:0];
                    yo_d   = sum_y[Y_W-1:0];
                    co_d   = col_q;
                    plot_d = !clip;
                    if (cx_q == w_q - DIM_W'(1)) begin
                        cx_d = '0;
                        if (cy_q == h_q - DIM_W'(1)) begin
                            state_d = FLUSH;
                        end else begin
                            cy_d = cy_q + DIM_W'(1);
                        end
                    end else begin
                        cx_d = cx_q + DIM_W'(1);
                    end
                end
            end
            FLUSH: begin
                state_d = FINISH;
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == FINISH);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            x0_q    <= '0;
            y0_q    <= '0;
            w_q     <= '0;
            h_q     <= '0;
            col_q   <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            xo_q    <= '0;
            yo_q    <= '0;
            co_q    <= '0;
            plot_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x0_q    <= x0_d;
            y0_q    <= y0_d;
            w_q     <= w_d;
            h_q     <= h_d;
            col_q   <= col_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            xo_q    <= xo_d;
            yo_q    <= yo_d;
            co_q    <= co_d;
            plot_q  <= plot_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign x_out      = xo_q;
    assign y_out      = yo_q;
    assign colour_out = co_q;
    assign plot_out   = plot_q;

endmodule

// File: tb/tb_rect_drawer.sv
// tb_rect_drawer
// Self-checking bench for rect_drawer. A behavioural model lists the pixels of
// each rectangle in row-major order, places them on a cycle timeline (with
// stall cycles inserted) and checks the DUT outputs after every clock edge.
module tb_rect_drawer;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       erase = 1'b0;
    logic       hold  = 1'b0;
    logic [7:0] x_in = '0;
    logic [6:0] y_in = '0;
    logic [4:0] w_in = '0;
    logic [4:0] h_in = '0;
    logic [8:0] colour_in = '0;
    logic [8:0] bg_colour = '0;
    logic       busy, done, plot_out;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [8:0] colour_out;

    int total = 0;
    int bad   = 0;

    rect_drawer dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .erase      (erase),
        .hold       (hold),
        .x_in       (x_in),
        .y_in       (y_in),
        .w_in       (w_in),
        .h_in       (h_in),
        .colour_in  (colour_in),
        .bg_colour  (bg_colour),
        .busy       (busy),
        .done       (done),
        .x_out      (x_out),
        .y_out      (y_out),
        .colour_out (colour_out),
        .plot_out   (plot_out)
    );

    always #5 clock = ~clock;

    // Draws one rectangle and checks every cycle from the start edge until
    // two cycles after the draw ends. hold_at is the pixel count after which
    // hold is raised for hold_len cycles (needs 1 <= hold_at < w*h).
    task automatic run_rect(input int x, input int y, input int w, input int h,
                            input int col, input int bg, input int er,
                            input int hold_at, input int hold_len,
                            input int keep_start, input int scramble,
                            input string tag);
        int n, hl, last, pix, ex, ey, ec, eplot, sx, sy;
        int plots_seen, plots_exp;
        n  = w * h;
        hl = (n >= 2) ? hold_len : 0;
        ec = (er != 0) ? bg : col;
        plots_seen = 0;
        plots_exp  = 0;
        @(negedge clock);
        x_in      = 8'(x);
        y_in      = 7'(y);
        w_in      = 5'(w);
        h_in      = 5'(h);
        colour_in = 9'(col);
        bg_colour = 9'(bg);
        erase     = (er != 0);
        hold      = 1'b0;
        start     = 1'b1;
        @(posedge clock);
        #1;
        if (keep_start == 0 || n == 0) start = 1'b0;
        if (scramble != 0) begin
            x_in      = 8'($urandom);
            y_in      = 7'($urandom);
            w_in      = 5'($urandom);
            h_in      = 5'($urandom);
            colour_in = 9'($urandom);
            bg_colour = 9'($urandom);
            erase     = 1'($urandom);
        end
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL %s busy_after_start got=%b want=1", tag, busy);
        end
        if (n == 0) begin
            total++;
            if (done !== 1'b1 || plot_out !== 1'b0) begin
                bad++;
                $display("FAIL %s zero_size_finish got done=%b plot=%b want done=1 plot=0",
                         tag, done, plot_out);
            end
            for (int c = 1; c <= 2; c++) begin
                @(posedge clock);
                #1;
                total++;
                if (busy !== 1'b0 || done !== 1'b0 || plot_out !== 1'b0) begin
                    bad++;
                    $display("FAIL %s zero_size_after c=%0d got busy=%b done=%b plot=%b want 0 0 0",
                             tag, c, busy, done, plot_out);
                end
            end
            $display("rect %s x=%0d y=%0d w=%0d h=%0d -> empty", tag, x, y, w, h);
            return;
        end
        total++;
        if (done !== 1'b0 || plot_out !== 1'b0) begin
            bad++;
            $display("FAIL %s first_cycle got done=%b plot=%b want 0 0", tag, done, plot_out);
        end
        pix   = 0;
        ex    = 0;
        ey    = 0;
        eplot = 0;
        last  = n + hl;
        for (int c = 1; c <= last + 3; c++) begin
            @(posedge clock);
            #1;
            if (c <= last) begin
                if (c > hold_at && c <= hold_at + hl) begin
                    eplot = 0;
                end else begin
                    sx    = x + (pix % w);
                    sy    = y + (pix / w);
                    ex    = sx % 256;
                    ey    = sy % 128;
                    eplot = (sx < 160 && sy < 120) ? 1 : 0;
                    pix++;
                end
                plots_exp += eplot;
                total++;
                if (plot_out !== 1'(eplot)) begin
                    bad++;
                    $display("FAIL %s plot c=%0d got=%b want=%0d", tag, c, plot_out, eplot);
                end
                total++;
                if (x_out !== 8'(ex) || y_out !== 7'(ey)) begin
                    bad++;
                    $display("FAIL %s xy c=%0d got=(%0d,%0d) want=(%0d,%0d)",
                             tag, c, x_out, y_out, ex, ey);
                end
                total++;
                if (colour_out !== 9'(ec)) begin
                    bad++;
                    $display("FAIL %s colour c=%0d got=%h want=%h", tag, c, colour_out, 9'(ec));
                end
                total++;
                if (busy !== 1'b1 || done !== 1'b0) begin
                    bad++;
                    $display("FAIL %s busy_done_draw c=%0d got busy=%b done=%b want 1 0",
                             tag, c, busy, done);
                end
            end else if (c == last + 1) begin
                total++;
                if (done !== 1'b1 || busy !== 1'b1 || plot_out !== 1'b0) begin
                    bad++;
                    $display("FAIL %s done_pulse c=%0d got done=%b busy=%b plot=%b want 1 1 0",
                             tag, c, done, busy, plot_out);
                end
            end else begin
                total++;
                if (done !== 1'b0 || busy !== 1'b0 || plot_out !== 1'b0) begin
                    bad++;
                    $display("FAIL %s idle_after c=%0d got done=%b busy=%b plot=%b want 0 0 0",
                             tag, c, done, busy, plot_out);
                end
            end
            if (plot_out === 1'b1) plots_seen++;
            hold = (hl > 0 && c >= hold_at && c < hold_at + hl);
            if (keep_start != 0 && c == last + 1) start = 1'b0;
        end
        hold = 1'b0;
        total++;
        if (plots_seen != plots_exp) begin
            bad++;
            $display("FAIL %s plot_count got=%0d want=%0d", tag, plots_seen, plots_exp);
        end
        $display("rect %s x=%0d y=%0d w=%0d h=%0d hold=%0d@%0d -> plots=%0d",
                 tag, x, y, w, h, hl, hold_at, plots_seen);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || plot_out !== 1'b0 ||
            x_out !== 8'd0 || y_out !== 7'd0 || colour_out !== 9'd0) begin
            bad++;
            $display("FAIL reset_state got busy=%b done=%b plot=%b x=%0d y=%0d c=%h want all 0",
                     busy, done, plot_out, x_out, y_out, colour_out);
        end
        start = 1'b0;
        reset = 1'b1;
        $display("reset: outputs checked");
    endtask

    task automatic test_basic();
        run_rect(10, 20, 8, 8, 'h1C0, 0, 0, 0, 0, 0, 0, "basic8x8");
    endtask

    task automatic test_erase();
        run_rect(0, 0, 3, 2, 'h155, 0, 1, 0, 0, 0, 0, "erase3x2");
    endtask

    task automatic test_zero_size();
        run_rect(4, 4, 0, 5, 'h0AA, 0, 0, 0, 0, 0, 0, "zero_w");
        run_rect(4, 4, 6, 0, 'h0AA, 0, 0, 0, 0, 0, 0, "zero_h");
    endtask

    task automatic test_clip();
        run_rect(157, 118, 5, 4, 'h1FF, 0, 0, 0, 0, 0, 0, "clip_corner");
        run_rect(250, 125, 9, 3, 'h033, 0, 0, 0, 0, 0, 0, "clip_wrap");
    endtask

    task automatic test_hold();
        run_rect(30, 40, 4, 4, 'h0F0, 0, 0, 4, 3, 0, 0, "hold4x4");
    endtask

    task automatic test_reset_abort();
        @(negedge clock);
        x_in = 8'd5; y_in = 7'd5; w_in = 5'd16; h_in = 5'd16;
        colour_in = 9'h12A; erase = 1'b0; start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clock);
            #1;
            start = (c == 2);
        end
        total++;
        if (plot_out !== 1'b1 || x_out !== 8'd14 || y_out !== 7'd5) begin
            bad++;
            $display("FAIL abort_pixel10 got plot=%b (%0d,%0d) want 1 (14,5)", plot_out, x_out, y_out);
        end
        reset = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || plot_out !== 1'b0 ||
            x_out !== 8'd0 || y_out !== 7'd0 || colour_out !== 9'd0) begin
            bad++;
            $display("FAIL abort_outputs got busy=%b done=%b plot=%b x=%0d y=%0d c=%h want all 0",
                     busy, done, plot_out, x_out, y_out, colour_out);
        end
        for (int c = 0; c < 20; c++) begin
            @(posedge clock);
            #1;
            total++;
            if (busy !== 1'b0 || done !== 1'b0 || plot_out !== 1'b0) begin
                bad++;
                $display("FAIL abort_quiet c=%0d got busy=%b done=%b plot=%b want 0 0 0",
                         c, busy, done, plot_out);
            end
        end
        $display("abort: reset mid-draw checked");
        run_rect(100, 60, 5, 3, 'h0C3, 0, 0, 0, 0, 0, 0, "after_abort");
    endtask

    task automatic test_back_to_back();
        run_rect(12, 7, 3, 3, 'h111, 'h022, 0, 0, 0, 1, 0, "b2b_a");
        run_rect(20, 9, 4, 2, 'h111, 'h022, 1, 2, 2, 1, 0, "b2b_b");
    endtask

    task automatic test_random();
        int w, h, ha, hl;
        for (int i = 0; i < 8; i++) begin
            w  = $urandom_range(0, 31);
            h  = $urandom_range(0, 31);
            hl = 0;
            ha = 0;
            if (w * h >= 2 && $urandom_range(0, 1) == 1) begin
                ha = $urandom_range(1, w * h - 1);
                hl = $urandom_range(1, 5);
            end
            run_rect($urandom_range(0, 255), $urandom_range(0, 127), w, h,
                     $urandom_range(0, 511), $urandom_range(0, 511),
                     $urandom_range(0, 1), ha, hl, $urandom_range(0, 1), 1, "random");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_erase();
        test_zero_size();
        test_clip();
        test_hold();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
